// File: rtl/crypt_pkg.sv
// -----------------------------------------------------------------------------
// crypt_pkg
//   Shared types and constants for the encryption-engine scheduler.
//   - state_t : scheduler FSM states (IDLE, GRANT)
//   - tag_t   : per-byte tag that travels alongside the engine pipeline
//   - BYTE_W  : byte width, must match the encryption engine
//   - KEY_CNT : number of rotating keys in the engine (phase wraps at this)
// -----------------------------------------------------------------------------
package crypt_pkg;

   localparam int BYTE_W   = 8;
   localparam int KEY_CNT  = 3;
   // Tag ID field is sized for the largest supported requester count (8).
   localparam int ID_W_MAX = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic [ID_W_MAX-1:0] id;
      logic                last;
      logic [1:0]          phase;
      logic                valid;
   } tag_t;

   // Key phase sequence 0 -> 1 -> 2 -> 0, mirroring the engine's key rotation.
   function automatic logic [1:0] next_phase(input logic [1:0] p);
      return (p == 2'(KEY_CNT - 1)) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/crypt_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Returns the first asserted
//   request index at or after ptr, wrapping past NREQ-1 back to 0.
//   Ports:
//     req   in  NREQ  request vector
//     ptr   in  IW    search start index
//     grant out IW    chosen index (0 when none)
//     any   out 1     at least one request asserted
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   grant,
   output logic            any
);

   int idx;

   // Walk offsets from farthest to nearest so the nearest hit to ptr is the
   // last assignment and therefore wins.
   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) begin
            grant = IW'(idx);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/crypt_sched.sv
// -----------------------------------------------------------------------------
// crypt_sched
//   Packet-level round-robin scheduler sharing one byte-wide encryption
//   engine between NREQ requesters. A requester keeps the engine for a whole
//   packet; each byte sent to the engine is tagged {id, last, phase} and the
//   tag is re-attached to the engine result ENG_LAT cycles later.
//   Ports:
//     clock, rst            clock (rising) / async active-low reset
//     req_valid/data/last   per-requester byte stream (requester i at [i*W +: W])
//     req_ready             per-requester accept (only the owner, only in GRANT)
//     eng_en/eng_din        byte into the engine
//     eng_dout/eng_v        engine result
//     out_valid/data/id/last/phase   registered tagged result (no backpressure)
//     busy                  FSM not idle or bytes still in the engine
//     err                   sticky: engine valid disagreed with the tag pipe
// -----------------------------------------------------------------------------
module crypt_sched
   import crypt_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int W       = BYTE_W,
   parameter  int ENG_LAT = 2,
   localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic              eng_en,
   output logic [W-1:0]      eng_din,
   input  logic [W-1:0]      eng_dout,
   input  logic              eng_v,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [IW-1:0]     out_id,
   output logic              out_last,
   output logic [1:0]        out_phase,
   output logic              busy,
   output logic              err
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t                 state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [1:0]             phase_q, phase_d;
   tag_t [ENG_LAT-1:0]     tag_q, tag_d;
   logic                   out_valid_q, out_valid_d;
   logic [W-1:0]           out_data_q, out_data_d;
   logic [IW-1:0]          out_id_q, out_id_d;
   logic                   out_last_q, out_last_d;
   logic [1:0]             out_phase_q, out_phase_d;
   logic                   err_q, err_d;

   logic [IW-1:0]          pick_idx;
   logic                   pick_any;
   tag_t                   new_tag;
   tag_t                   tail;
   logic                   inflight;
   logic                   unused_tail_id;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (pick_idx),
      .any   (pick_any)
   );

   // -------------------------------------------------------------------------
   // FSM, phase counter and engine drive
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      phase_d   = phase_q;
      req_ready = '0;
      eng_en    = 1'b0;
      eng_din   = '0;
      new_tag   = '0;

      case (state_q)
         IDLE: begin
            // The owner is latched here and granted next cycle, so ready never
            // depends combinationally on the picker.
            if (pick_any) begin
               owner_d = pick_idx;
               state_d = GRANT;
            end
         end

         GRANT: begin
            req_ready[owner_q] = 1'b1;
            if (req_valid[owner_q]) begin
               eng_en        = 1'b1;
               eng_din       = req_data[int'(owner_q)*W +: W];
               new_tag.valid = 1'b1;
               new_tag.id    = ID_W_MAX'(owner_q);
               new_tag.last  = req_last[owner_q];
               new_tag.phase = phase_q;
               // Phase only moves with real engine traffic so it stays in step
               // with the engine's own key rotation.
               phase_d       = next_phase(phase_q);
               if (req_last[owner_q]) begin
                  ptr_d   = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
                  state_d = IDLE;
               end
            end
            // A stalled owner keeps the grant; the pushed tag is a bubble.
         end

         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Tag pipe: one entry per cycle (bubbles included) so the tail lines up
   // with the engine result exactly ENG_LAT cycles after eng_en.
   // -------------------------------------------------------------------------
   always_comb begin
      tag_d    = tag_q;
      tag_d[0] = new_tag;
      for (int i = 1; i < ENG_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   assign tail = tag_q[ENG_LAT-1];

   always_comb begin
      inflight = 1'b0;
      for (int i = 0; i < ENG_LAT; i++) begin
         inflight |= tag_q[i].valid;
      end
   end

   // Upper tag ID bits are only meaningful for the largest NREQ.
   assign unused_tail_id = ^tail.id;

   // -------------------------------------------------------------------------
   // Output register and error check
   // -------------------------------------------------------------------------
   always_comb begin
      out_valid_d = tail.valid;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      out_last_d  = out_last_q;
      out_phase_d = out_phase_q;
      if (tail.valid) begin
         out_data_d  = eng_dout;
         out_id_d    = IW'(tail.id);
         out_last_d  = tail.last;
         out_phase_d = tail.phase;
      end
      // Any disagreement means the engine and our tag pipe have slipped.
      err_d = err_q | (tail.valid != eng_v);
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         phase_q     <= '0;
         tag_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         out_last_q  <= 1'b0;
         out_phase_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         phase_q     <= phase_d;
         tag_q       <= tag_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         out_last_q  <= out_last_d;
         out_phase_q <= out_phase_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign out_last  = out_last_q;
   assign out_phase = out_phase_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE) | inflight;

endmodule
